// File: rtl/contador_mon_pkg.sv
// ----------------------------------------------------------------------------
// contador_mon_pkg
// Shared mode and FSM state encodings for the contador_mon counter monitor.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package contador_mon_pkg;

  // Counter operating modes, as driven to the monitored counter
  localparam logic [1:0] MODE_UP3  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_UP1  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Monitor sequencing: wait out the counter's post-reset transient before comparing
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    CHECK  = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/contador_ref_model.sv
// ----------------------------------------------------------------------------
// contador_ref_model
// Purely combinational next-value predictor for the 4-bit counter, including
// the load flag and the ripple-carry-out on arithmetic wrap.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module contador_ref_model
  import contador_mon_pkg::*;
(
  input  logic [3:0] cur_q,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [3:0] d,
  output logic [3:0] nxt_q,
  output logic       nxt_load,
  output logic       nxt_rco
);

  logic [4:0] sum;

  // Next counter value and flags; a disabled counter holds with both flags low
  always_comb begin
    nxt_q    = cur_q;
    nxt_load = 1'b0;
    nxt_rco  = 1'b0;
    sum      = 5'd0;
    if (enable) begin
      case (mode)
        MODE_UP3: begin
          sum     = {1'b0, cur_q} + 5'd3;
          nxt_q   = sum[3:0];
          nxt_rco = sum[4];
        end
        MODE_DN1: begin
          nxt_q   = cur_q - 4'd1;
          nxt_rco = (cur_q == 4'd0);
        end
        MODE_UP1: begin
          sum     = {1'b0, cur_q} + 5'd1;
          nxt_q   = sum[3:0];
          nxt_rco = sum[4];
        end
        default: begin
          nxt_q    = d;
          nxt_load = 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/contador_mon.sv
// ----------------------------------------------------------------------------
// contador_mon
// Runtime monitor for a registered 4-bit up/down/load counter. Predicts the
// counter's value and flags each cycle, compares the observed outputs once the
// post-reset settle period is over, pulses err on a mismatch and keeps a
// saturating mismatch total.
// Build option: define CONTADOR_MON_FLAGS_EN to include load/rco in the
// comparison (by default only Q is compared).
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module contador_mon
  import contador_mon_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             load,
  input  logic             rco,
  output logic [3:0]       exp_Q,
  output logic             exp_load,
  output logic             exp_rco,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             checking
);

  state_t     state, state_nxt;
  logic [3:0] nxt_q;
  logic       nxt_load;
  logic       nxt_rco;
  logic       mismatch;

  contador_ref_model u_ref (
    .cur_q    (exp_Q),
    .enable   (enable),
    .mode     (mode),
    .d        (D),
    .nxt_q    (nxt_q),
    .nxt_load (nxt_load),
    .nxt_rco  (nxt_rco)
  );

`ifdef CONTADOR_MON_FLAGS_EN
  assign mismatch = (Q != exp_Q) || (load != exp_load) || (rco != exp_rco);
`else
  // Flags are observed but deliberately left out of the comparison
  logic unused_flags;
  assign unused_flags = load ^ rco;
  assign mismatch     = (Q != exp_Q);
`endif

  assign checking = (state == CHECK);

  // Prediction registers track the counter edge for edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_Q    <= 4'd0;
      exp_load <= 1'b0;
      exp_rco  <= 1'b0;
    end else begin
      exp_Q    <= nxt_q;
      exp_load <= nxt_load;
      exp_rco  <= nxt_rco;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: two settle edges after reset, then check until reset
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = SETTLE;
      SETTLE:  state_nxt = CHECK;
      CHECK:   state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  // Compare against the prediction held before this edge; count saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= checking && mismatch;
      if (checking && mismatch && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: doc/contador_mon.md
CONTADOR_MON -- requirements
Module: contador_mon

Interface
REQ-001 SHALL have parameter ERR_W, default 8, meaning width of the mismatch counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock shared with the monitored counter.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  counter enable, as driven to the counter.
REQ-005 SHALL have port mode  input  2  counter mode, as driven to the counter.
REQ-006 SHALL have port D  input  4  counter load data.
REQ-007 SHALL have port Q  input  4  observed counter value.
REQ-008 SHALL have port load  input  1  observed counter load flag.
REQ-009 SHALL have port rco  input  1  observed counter ripple-carry-out.
REQ-010 SHALL have port exp_Q  output  4  predicted counter value.
REQ-011 SHALL have port exp_load, exp_rco  output  1 each  predicted flags.
REQ-012 SHALL have port err  output  1  one-cycle mismatch pulse.
REQ-013 SHALL have port err_count  output  ERR_W  saturating mismatch total.
REQ-014 SHALL have port checking  output  1  high while in state CHECK.

Function
REQ-015 SHALL model the counter as registered: at each rising clk edge, enable=0 holds exp_Q with exp_load=0 and exp_rco=0.
REQ-016 With enable=1, mode 00 SHALL set exp_Q to exp_Q+3 mod 16.
REQ-017 With enable=1, mode 01 SHALL set exp_Q to exp_Q-1 mod 16.
REQ-018 With enable=1, mode 10 SHALL set exp_Q to exp_Q+1 mod 16.
REQ-019 With enable=1, mode 11 SHALL set exp_Q to D with exp_load=1.
REQ-020 exp_rco SHALL be 1 exactly on the edge where arithmetic wraps (+3 from 13..15, -1 from 0, +1 from 15), else 0; exp_load SHALL be 0 in modes 00/01/10.
REQ-021 FSM SHALL have states IDLE, SETTLE and CHECK: reset forces IDLE; IDLE->SETTLE on the first edge after reset release; SETTLE->CHECK on the next edge; CHECK holds until reset.
REQ-022 In CHECK, each edge SHALL compare sampled Q against exp_Q as held before that edge; a mismatch SHALL set err=1 for exactly one cycle, 1 cycle after the offending Q appears.
REQ-023 err_count SHALL increment by 1 per mismatch and saturate at 2^ERR_W-1 without wrap; err still pulses at saturation.
REQ-024 No comparison SHALL occur in IDLE or SETTLE; err SHALL be 0 there.
REQ-025 Reset asserted mid-operation SHALL abort checking immediately (asynchronous) and discard any pending compare.

Reset
REQ-026 While reset=0: exp_Q=0, exp_load=0, exp_rco=0, err=0, err_count=0, checking=0, state=IDLE.
REQ-027 The model SHALL begin predicting from exp_Q=0 on the first edge after release.

Configuration
REQ-028 Macro CONTADOR_MON_FLAGS_EN: when defined, a mismatch SHALL be any difference in Q, load or rco; when undefined, only Q SHALL be compared, and exp_load/exp_rco SHALL still be driven.

Structure
REQ-029 Package contador_mon_pkg SHALL hold the mode encodings (MODE_UP3=00, MODE_DN1=01, MODE_UP1=10, MODE_LOAD=11) and the FSM state encodings.
REQ-030 Next-value and wrap prediction SHALL live in one sub-module, contador_ref_model, which is purely combinational. The top level SHALL hold the registers, the FSM and the error logic.

Verification
REQ-031 Reset, then enable=1 with mode=10 for 20 cycles against a correct counter -> exp_Q steps 1..15,0,1..; exp_rco=1 on the 15->0 step; err_count stays 0.
REQ-032 Mode=11 with D=4'hD, then mode=00 for 2 cycles -> exp_Q sequence D, 0, 3; exp_load=1 on the first step only; exp_rco=1 on the D->0 step.
REQ-033 Mode=01 from 0 -> exp_Q=15 with exp_rco=1; enable=0 for 3 cycles -> exp_Q held at 15 with flags 0.
REQ-034 Force Q to 4'h7 while exp_Q=4'h5 in CHECK -> err=1 for one cycle on the next edge; err_count=1.
REQ-035 With CONTADOR_MON_FLAGS_EN defined, force rco=1 while exp_rco=0 -> err pulse; with the macro undefined -> no err.
REQ-036 Inject 300 mismatches with ERR_W=8 -> err_count=255; assert reset mid-stream -> all outputs 0 asynchronously; err stays 0 for the 2 cycles after release.
